// File: rtl/arb4_handshake_if.sv
`default_nettype none
// ============================================================================
// Module : arb4_handshake_if
// Client handshake and arbiter request/grant bundle for arb4_handshake.
// Rev    : 1.0
// ============================================================================
interface arb4_handshake_if;
  logic [3:0] cli_req;
  logic [3:0] cli_done;
  logic [3:0] cli_ack;
  logic [3:0] arb_req;
  logic [3:0] arb_gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout_err;
  logic       conflict_err;

  modport master (
    output cli_req, cli_done, arb_gnt,
    input  cli_ack, arb_req, owner, busy, timeout_err, conflict_err
  );

  modport slave (
    input  cli_req, cli_done, arb_gnt,
    output cli_ack, arb_req, owner, busy, timeout_err, conflict_err
  );
endinterface
`default_nettype wire

// File: rtl/arb4_handshake.sv
`default_nettype none
// ============================================================================
// Module : arb4_handshake
// Four-phase client front end for a 4-way mutex arbiter: grant sync,
// bounded ownership time and grant-exclusivity monitoring.
// Rev    : 1.0
// ============================================================================
module arb4_handshake #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 255,
  parameter int CW          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  arb4_handshake_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  gs;

  state_t        state_q [4];
  state_t        state_d [4];

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    arb_req_q;
  logic [3:0]    cli_ack_q;
  logic [1:0]    owner_q;
  logic          busy_q;
  logic          timeout_q;
  logic          conflict_q;

  logic [3:0]    in_grant;
  logic [3:0]    want_grant;
  logic [3:0]    enter_grant;
  logic [3:0]    grant_d;
  logic [3:0]    req_d;
  logic [1:0]    owner_d;
  logic          any_grant;
  logic          hold_hit;
  logic          timeout_d;
  logic          conflict_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.arb_gnt};
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  always_comb begin
    in_grant   = '0;
    want_grant = '0;
    for (int i = 0; i < 4; i++) begin
      in_grant[i]   = (state_q[i] == S_GRANT);
      want_grant[i] = (state_q[i] == S_REQ) && gs[i];
    end
  end

  assign any_grant = |in_grant;
  assign hold_hit  = (cnt_q == HOLD_LAST);

  // Lowest index wins a simultaneous entry; nobody enters while the resource is held.
  assign enter_grant = any_grant ? 4'b0000 : (want_grant & (~want_grant + 4'd1));

  assign conflict_d = conflict_q
                    | ((gs & (gs - 4'd1)) != 4'd0)
                    | ((want_grant & (want_grant - 4'd1)) != 4'd0);

  always_comb begin
    timeout_d = 1'b0;
    grant_d   = '0;
    req_d     = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (bus.cli_req[i]) state_d[i] = S_REQ;
        end
        S_REQ: begin
          if (enter_grant[i])       state_d[i] = S_GRANT;
          else if (!bus.cli_req[i]) state_d[i] = S_RELEASE;
        end
        S_GRANT: begin
          if (bus.cli_done[i]) begin
            state_d[i] = S_RELEASE;
          end else if (hold_hit) begin
            state_d[i] = S_RELEASE;
            timeout_d  = 1'b1;
          end
        end
        S_RELEASE: begin
          // Wait for the mutex to drop its grant before a new request can start.
          if (!gs[i] && !bus.cli_req[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
      grant_d[i] = (state_d[i] == S_GRANT);
      req_d[i]   = (state_d[i] == S_REQ) || (state_d[i] == S_GRANT);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|enter_grant) begin
      cnt_d = '0;
    end else if (any_grant && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign owner_d = {grant_d[3] | grant_d[2], grant_d[3] | grant_d[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) state_q[i] <= S_IDLE;
      cnt_q      <= '0;
      arb_req_q  <= '0;
      cli_ack_q  <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) state_q[i] <= state_d[i];
      cnt_q      <= cnt_d;
      arb_req_q  <= req_d;
      cli_ack_q  <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= |grant_d;
      timeout_q  <= timeout_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.arb_req      = arb_req_q;
  assign bus.cli_ack      = cli_ack_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.conflict_err = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_arb4_handshake.sv
`default_nettype none
// ============================================================================
// Module : tb_arb4_handshake
// Randomised and directed bench for arb4_handshake against a reference model.
// Rev    : 1.0
// ============================================================================
module tb_arb4_handshake;
  localparam int SYNC = 2;
  localparam int HOLD = 8;
  localparam int CW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb4_handshake_if bus ();

  arb4_handshake #(
    .SYNC_STAGES(SYNC),
    .HOLD_MAX   (HOLD),
    .CW         (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the resource, who is waiting, who is draining.
  int         m_own;
  int         m_left;
  logic [3:0] m_wait;
  logic [3:0] m_drain;
  logic [3:0] m_sh [SYNC];
  logic       m_conf;
  logic       m_tmo;

  // Environment state.
  bit   arb_auto, cli_auto, cli_rand;
  int   arb_mode, a_own, a_wait, a_delay, a_gnt_cycle;
  int   order_q[$];
  int   hold_len[4], ackcnt[4], ack_hi[4];
  int   ack_order[$];
  int   cyc, tmo_cnt, rises;
  logic [3:0] prev_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_left = 0; m_wait = '0; m_drain = '0; m_conf = 1'b0; m_tmo = 1'b0;
    for (int s = 0; s < SYNC; s++) m_sh[s] = '0;
  endtask

  task automatic model_step();
    logic [3:0] gs, cand, nw, nd;
    int nown, win;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gs    = m_sh[SYNC-1];
    m_tmo = 1'b0;
    cand  = m_wait & gs;
    if ($countones(gs) > 1 || $countones(cand) > 1) m_conf = 1'b1;
    nw = m_wait; nd = m_drain; nown = m_own;
    for (int i = 0; i < 4; i++)
      if (m_drain[i] && !gs[i] && !bus.cli_req[i]) nd[i] = 1'b0;
    if (m_own >= 0) begin
      if (bus.cli_done[m_own]) begin
        nd[m_own] = 1'b1; nown = -1;
      end else if (m_left == 1) begin
        nd[m_own] = 1'b1; nown = -1; m_tmo = 1'b1;
      end else begin
        m_left--;
      end
    end
    win = -1;
    if (m_own < 0)
      for (int i = 3; i >= 0; i--) if (cand[i]) win = i;
    for (int i = 0; i < 4; i++) begin
      if (m_wait[i]) begin
        if (i == win) begin
          nw[i] = 1'b0; nown = i; m_left = HOLD;
        end else if (!bus.cli_req[i]) begin
          nw[i] = 1'b0; nd[i] = 1'b1;
        end
      end else if (!m_drain[i] && m_own != i && bus.cli_req[i]) begin
        nw[i] = 1'b1;
      end
    end
    m_wait = nw; m_drain = nd; m_own = nown;
    for (int s = SYNC - 1; s > 0; s--) m_sh[s] = m_sh[s-1];
    m_sh[0] = bus.arb_gnt;
  endtask

  task automatic compare_all();
    logic [3:0] exp_ack;
    exp_ack = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    check_eq("cli_ack", bus.cli_ack, exp_ack);
    check_eq("arb_req", bus.arb_req, m_wait | exp_ack);
    check_eq("owner", bus.owner, (m_own >= 0) ? m_own : 0);
    check_eq("busy", bus.busy, m_own >= 0);
    check_eq("timeout_err", bus.timeout_err, m_tmo);
    check_eq("conflict_err", bus.conflict_err, m_conf);
    check_eq("ack_exclusive", $countones(bus.cli_ack) <= 1, 1);
  endtask

  function automatic int next_delay();
    return (a_delay >= 0) ? a_delay : int'($urandom_range(0, 4));
  endfunction

  task automatic drive_arbiter();
    int start, idx;
    if (!arb_auto) return;
    if (a_own >= 0) begin
      if (!bus.arb_req[a_own]) begin
        bus.arb_gnt = '0; a_own = -1; a_wait = next_delay();
      end
    end else if (bus.arb_req != 4'b0000) begin
      if (a_wait > 0) begin
        a_wait--;
      end else begin
        idx = -1;
        if (arb_mode == 1) begin
          if (order_q.size() > 0 && bus.arb_req[order_q[0]]) idx = order_q.pop_front();
        end else begin
          start = $urandom_range(0, 3);
          for (int k = 3; k >= 0; k--) if (bus.arb_req[(start + k) % 4]) idx = (start + k) % 4;
        end
        if (idx >= 0) begin
          a_own = idx; bus.arb_gnt = 4'(1 << idx); a_gnt_cycle = cyc;
        end
      end
    end
  endtask

  task automatic drive_clients();
    if (!cli_auto) return;
    for (int i = 0; i < 4; i++) begin
      bus.cli_done[i] = 1'b0;
      if (bus.cli_ack[i]) begin
        ackcnt[i]++;
        if (ackcnt[i] >= hold_len[i] && bus.cli_req[i]) begin
          bus.cli_done[i] = 1'b1; bus.cli_req[i] = 1'b0;
        end
      end else if (ackcnt[i] > 0 && bus.cli_req[i]) begin
        bus.cli_req[i] = 1'b0;
      end else if (cli_rand) begin
        if (bus.cli_req[i]) begin
          if ($urandom_range(0, 31) == 0) bus.cli_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.cli_req[i] = 1'b1; ackcnt[i] = 0; hold_len[i] = $urandom_range(1, 11);
        end
        if ($urandom_range(0, 7) == 0) bus.cli_done[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all();
    for (int i = 0; i < 4; i++) begin
      if (bus.cli_ack[i] && !prev_ack[i]) begin
        ack_order.push_back(i); rises++;
      end
      if (bus.cli_ack[i]) ack_hi[i]++;
    end
    if (bus.timeout_err) tmo_cnt++;
    prev_ack = bus.cli_ack;
    drive_arbiter();
    drive_clients();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_ack(input int i, input int max_cyc, input string tag);
    for (int k = 0; k < max_cyc && !bus.cli_ack[i]; k++) step();
    check_eq(tag, bus.cli_ack[i], 1);
  endtask

  task automatic reset_clients();
    for (int i = 0; i < 4; i++) begin
      ackcnt[i] = 0; ack_hi[i] = 0; hold_len[i] = 3;
    end
    bus.cli_done = '0;
    tmo_cnt = 0;
  endtask

  initial begin
    bus.cli_req = '0; bus.cli_done = '0; bus.arb_gnt = '0;
    arb_auto = 1'b0; cli_auto = 1'b0; cli_rand = 1'b0;
    arb_mode = 0; a_own = -1; a_wait = 0; a_delay = 0; a_gnt_cycle = 0;
    cyc = 0; rises = 0; prev_ack = '0;
    model_reset();
    reset_clients();

    // Reset state.
    steps(3);
    check_eq("reset_arb_req", bus.arb_req, 0);
    @(negedge clk) rst_n = 1'b1;
    steps(2);

    // Single client, grant after a delay.
    arb_auto = 1'b1; cli_auto = 1'b1; arb_mode = 0; a_delay = 5; a_wait = 5;
    reset_clients(); hold_len[2] = 2;
    bus.cli_req = 4'b0100;
    step();
    check_eq("single_arb_req", bus.arb_req, 4'b0100);
    wait_ack(2, 40, "single_ack");
    check_eq("single_gnt_to_ack", cyc - a_gnt_cycle, SYNC + 1);
    check_eq("single_owner", bus.owner, 2);
    check_eq("single_busy", bus.busy, 1);
    steps(15);
    check_eq("single_released", bus.arb_req, 0);

    // Contention, arbiter order 3,1,0,2.
    reset_clients(); ack_order.delete();
    arb_mode = 1; a_delay = 2; a_wait = 2;
    order_q = '{3, 1, 0, 2};
    bus.cli_req = 4'b1111;
    for (int k = 0; k < 200 && (ack_order.size() < 4 || bus.arb_req != 0); k++) step();
    check_eq("cont_count", ack_order.size(), 4);
    if (ack_order.size() == 4) begin
      check_eq("cont_order0", ack_order[0], 3);
      check_eq("cont_order1", ack_order[1], 1);
      check_eq("cont_order2", ack_order[2], 0);
      check_eq("cont_order3", ack_order[3], 2);
    end
    check_eq("cont_conflict", bus.conflict_err, 0);
    steps(6);

    // Timeout without done, then done coinciding with the timeout.
    arb_mode = 0; a_delay = 1; a_wait = 1;
    reset_clients(); hold_len[0] = 1000;
    bus.cli_req = 4'b0001;
    steps(40);
    check_eq("tmo_ack_cycles", ack_hi[0], HOLD);
    check_eq("tmo_pulses", tmo_cnt, 1);
    check_eq("tmo_arb_req", bus.arb_req, 0);
    reset_clients(); hold_len[1] = HOLD;
    bus.cli_req = 4'b0010;
    steps(40);
    check_eq("tmo_done_ack_cycles", ack_hi[1], HOLD);
    check_eq("tmo_done_no_pulse", tmo_cnt, 0);

    // Abandoned request, then a late grant while releasing.
    arb_auto = 1'b0; cli_auto = 1'b0;
    reset_clients();
    bus.cli_req = 4'b0010;
    step();
    check_eq("abandon_arb_req_hi", bus.arb_req, 4'b0010);
    step();
    bus.cli_req = 4'b0000;
    step();
    check_eq("abandon_arb_req_lo", bus.arb_req, 4'b0000);
    bus.arb_gnt = 4'b0010;
    steps(5);
    bus.arb_gnt = 4'b0000;
    steps(5);
    check_eq("abandon_never_acked", ack_hi[1], 0);

    // Grant-exclusivity fault.
    bus.cli_req = 4'b0011;
    steps(2);
    bus.arb_gnt = 4'b0011;
    steps(SYNC);
    check_eq("fault_pre", bus.conflict_err, 0);
    step();
    check_eq("fault_set", bus.conflict_err, 1);
    check_eq("fault_ack", bus.cli_ack, 4'b0001);
    steps(4);
    check_eq("fault_sticky", bus.conflict_err, 1);
    check_eq("fault_ack_hold", bus.cli_ack, 4'b0001);
    bus.cli_done = 4'b0001; bus.cli_req = 4'b0000; bus.arb_gnt = 4'b0000;
    step();
    bus.cli_done = 4'b0000;
    steps(8);
    check_eq("fault_sticky_end", bus.conflict_err, 1);

    // Reset while client 3 holds the grant.
    arb_auto = 1'b1; cli_auto = 1'b1; a_delay = 1; a_wait = 1;
    reset_clients(); hold_len[3] = 1000;
    bus.cli_req = 4'b1000;
    wait_ack(3, 40, "rst_pre_grant");
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_ack", bus.cli_ack, 0);
    check_eq("rst_async_arb_req", bus.arb_req, 0);
    check_eq("rst_async_owner", bus.owner, 0);
    check_eq("rst_async_busy", bus.busy, 0);
    check_eq("rst_async_timeout", bus.timeout_err, 0);
    check_eq("rst_async_conflict", bus.conflict_err, 0);
    bus.cli_req = '0; bus.arb_gnt = '0; a_own = -1; a_wait = 1;
    reset_clients();
    steps(3);
    @(negedge clk) rst_n = 1'b1;
    hold_len[3] = 2;
    bus.cli_req = 4'b1000;
    wait_ack(3, 40, "rst_resume_ack");
    steps(20);

    // Randomised traffic.
    reset_clients();
    cli_rand = 1'b1; a_delay = -1; rises = 0;
    steps(3000);
    check_eq("rand_activity", rises >= 20, 1);
    cli_rand = 1'b0;
    for (int i = 0; i < 4; i++) if (!bus.cli_ack[i]) bus.cli_req[i] = 1'b0;
    steps(60);
    check_eq("rand_quiet", bus.arb_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/arb4_handshake.md
Name: arb4_handshake

Overview:
- Client-side front end for the 4-way mutex arbiter, sitting directly upstream of it.
- Drives the arbiter's four request lines from four per-client four-phase handshake FSMs.
- Synchronises the arbiter's grant lines back into the clk domain and returns registered acks to clients.
- Enforces a bounded ownership time and flags grant-exclusivity violations.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each arb_gnt bit before use; legal 2..4.
- HOLD_MAX, 255: maximum cycles a client may hold the grant before forced release; legal 1..65535.
- CW, 16: width of the hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cli_req  in  4  client request, bit i = client i; level, four-phase.
- cli_done  in  4  client finished with resource; sampled only while that client is in GRANT.
- cli_ack  out  4  grant acknowledge to client; registered.
- arb_req  out  4  to arbiter request inputs X3..X0 (bit i -> Xi); registered, glitch-free.
- arb_gnt  in  4  from arbiter grant outputs Y3..Y0 (bit i <- Yi); asynchronous to clk.
- owner  out  2  index of the client in GRANT; valid only when busy=1, 0 otherwise.
- busy  out  1  some client is in GRANT.
- timeout_err  out  1  one-cycle pulse when a forced release occurs.
- conflict_err  out  1  sticky; set when more than one synchronised grant bit is high; cleared only by reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All FSMs return to IDLE; synchronisers and counter clear.
  - cli_ack, arb_req, owner, busy, timeout_err and conflict_err are all 0.
- gs[i] is arb_gnt[i] after SYNC_STAGES flops. Only gs is used internally.
- Per-client FSM, four states:
  - IDLE: arb_req[i]=0, cli_ack[i]=0. If cli_req[i]=1, go to REQ.
  - REQ: arb_req[i]=1. If gs[i]=1, go to GRANT. If cli_req[i] drops first, go to RELEASE (abandoned request).
  - GRANT: cli_ack[i]=1, arb_req[i]=1, hold counter runs.
    - If cli_done[i]=1, go to RELEASE.
    - Else if the counter reaches HOLD_MAX-1, go to RELEASE and pulse timeout_err for 1 cycle.
    - If cli_done and timeout hit in the same cycle, cli_done wins and no timeout_err is raised.
  - RELEASE: arb_req[i]=0, cli_ack[i]=0. Go to IDLE only when gs[i]=0 and cli_req[i]=0; this prevents immediate re-request before the mutex has released.
- Latency:
  - arb_req rises 1 cycle after cli_req is sampled high.
  - cli_ack rises 1 cycle after gs rises, i.e. SYNC_STAGES+1 cycles after arb_gnt rises.
  - cli_ack falls 1 cycle after cli_done is sampled.
- Hold counter:
  - Single, shared; only one client may legally be in GRANT.
  - Loads 0 on any REQ->GRANT transition, increments each GRANT cycle, saturates (no wrap).
- owner/busy: combinational decode of the GRANT states, then registered.
- conflict_err:
  - Set if popcount(gs) > 1 in any cycle.
  - Set if two FSMs would enter GRANT in the same cycle. In that case the lowest index enters GRANT; the others stay in REQ.
- Simultaneous requests: all requesting clients assert arb_req in the same cycle. Ordering is decided solely by the arbiter.
- cli_done outside GRANT is ignored. cli_req toggling in RELEASE has no effect until gs[i]=0.
- Reset mid-grant drops arb_req immediately (asynchronously). No handshake completion is required.

Test Plan:
- Single client: cli_req=4'b0100, model grants Y2 5 cycles later.
  - Required: arb_req=4'b0100 at cycle 1; cli_ack[2]=1 at SYNC_STAGES+1 cycles after grant; owner=2, busy=1.
  - cli_done[2]=1 -> cli_ack=0 and arb_req=0 next cycle.
- Contention: cli_req=4'b1111, model grants 3,1,0,2 in turn.
  - Required: exactly one cli_ack bit high at any time, in order 3,1,0,2; conflict_err stays 0.
- Timeout: HOLD_MAX=8, client 0 granted, cli_done held 0.
  - Required: cli_ack[0] high for exactly 8 cycles; timeout_err pulses once; arb_req[0]=0 thereafter.
  - Done+timeout in the same cycle -> no pulse.
- Abandon: cli_req[1] pulsed high 2 cycles, no grant.
  - Required: arb_req[1] 1 -> 0, FSM returns to IDLE, cli_ack[1] never set.
  - Late grant arriving in RELEASE is not acked.
- Fault injection: arb_gnt=4'b0011 forced.
  - Required: conflict_err=1 after SYNC_STAGES+1 cycles, stays 1; only client 0 acked.
- Reset mid-grant: assert rst_n=0 while client 3 in GRANT.
  - Required: all outputs 0 within the same cycle; normal operation resumes after release.
